// File: rtl/pwm_setting_ctrl.sv
// Button-driven editor for the Count_CT / Count_F setting registers with debounce and auto-repeat.
// Define PWM_SETTING_CTRL_WRAP_EN to make steps wrap modulo 16 instead of saturating.
module pwm_setting_ctrl #(
    parameter int unsigned TICK_DIV        = 50000,
    parameter int unsigned DEB_TICKS       = 20,
    parameter int unsigned REP_DELAY_TICKS = 500,
    parameter int unsigned REP_RATE_TICKS  = 100,
    parameter logic [3:0]  CT_INIT         = 4'h8,
    parameter logic [3:0]  F_INIT          = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Funct_Select,
    input  logic       Btn_Up,
    input  logic       Btn_Down,
    output logic [3:0] Count_CT,
    output logic [3:0] Count_F,
    output logic       Update
);

    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW       = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam int unsigned HOLD_MAX = (REP_DELAY_TICKS > REP_RATE_TICKS) ? REP_DELAY_TICKS
                                                                           : REP_RATE_TICKS;
    localparam int unsigned HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_TICKS - 1);
    localparam logic [HW-1:0] DELAY_LAST = HW'(REP_DELAY_TICKS - 1);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REP_RATE_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    // Bit 0 is the Up button, bit 1 is the Down button throughout.
    logic [1:0]         btn_meta_q, btn_sync_q;
    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         deb_q, deb_d;
    state_t             state_q, state_d;
    logic [HW-1:0]      tcnt_q, tcnt_d;
    logic [3:0]         ct_q, ct_d, f_q, f_d;
    logic               upd_q, upd_d;
    logic               both_held, none_held, one_held;
    logic               step_fire, step_apply;
    logic [3:0]         sel_val, stepped_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= 2'b00;
            btn_sync_q <= 2'b00;
        end else begin
            btn_meta_q <= {Btn_Down, Btn_Up};
            btn_sync_q <= btn_meta_q;
        end
    end

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (btn_sync_q[b] == deb_q[b]) begin
                deb_cnt_d[b] = '0;
            end else if (tick) begin
                if (deb_cnt_q[b] == DEB_LAST) begin
                    deb_cnt_d[b] = '0;
                    deb_d[b]     = ~deb_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            deb_q     <= 2'b00;
            deb_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign both_held = &deb_q;
    assign none_held = ~|deb_q;
    assign one_held  = ^deb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (both_held)     state_d = S_LOCK;
                else if (one_held) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (none_held)                           state_d = S_IDLE;
                else if (both_held)                      state_d = S_LOCK;
                else if (tick && (tcnt_q == DELAY_LAST)) state_d = S_REPEAT;
            end
            S_REPEAT: begin
                if (none_held)      state_d = S_IDLE;
                else if (both_held) state_d = S_LOCK;
            end
            S_LOCK: begin
                if (none_held) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_fire = one_held &&
                    ((state_q == S_IDLE) ||
                     (tick && (state_q == S_HOLD)   && (tcnt_q == DELAY_LAST)) ||
                     (tick && (state_q == S_REPEAT) && (tcnt_q == RATE_LAST)));
    end

    // Hold/repeat tick counter restarts on every state entry and after each repeat step.
    always_comb begin
        tcnt_d = tcnt_q;
        if ((state_d != state_q) || ((state_q == S_REPEAT) && step_fire)) begin
            tcnt_d = '0;
        end else if (tick && ((state_q == S_HOLD) || (state_q == S_REPEAT))) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign sel_val     = Funct_Select ? ct_q : f_q;
    assign stepped_val = deb_q[0] ? (sel_val + 4'd1) : (sel_val - 4'd1);

`ifdef PWM_SETTING_CTRL_WRAP_EN
    assign step_apply = step_fire;
`else
    logic at_limit;
    assign at_limit   = deb_q[0] ? (sel_val == 4'hF) : (sel_val == 4'h0);
    assign step_apply = step_fire && !at_limit;
`endif

    always_comb begin
        ct_d  = ct_q;
        f_d   = f_q;
        upd_d = step_apply;
        if (step_apply) begin
            if (Funct_Select) ct_d = stepped_val;
            else              f_d  = stepped_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_q  <= CT_INIT;
            f_q   <= F_INIT;
            upd_q <= 1'b0;
        end else begin
            ct_q  <= ct_d;
            f_q   <= f_d;
            upd_q <= upd_d;
        end
    end

    assign Count_CT = ct_q;
    assign Count_F  = f_q;
    assign Update   = upd_q;

endmodule

// File: tb/tb_pwm_setting_ctrl.sv
// Self-checking bench for pwm_setting_ctrl against a cycle-level behavioural model.
module tb_pwm_setting_ctrl;

    localparam int TICK_DIV        = 4;
    localparam int DEB_TICKS       = 3;
    localparam int REP_DELAY_TICKS = 8;
    localparam int REP_RATE_TICKS  = 2;
    localparam logic [3:0] CT_INIT = 4'h8;
    localparam logic [3:0] F_INIT  = 4'h0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fsel = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] Count_CT, Count_F;
    logic       Update;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_setting_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .DEB_TICKS      (DEB_TICKS),
        .REP_DELAY_TICKS(REP_DELAY_TICKS),
        .REP_RATE_TICKS (REP_RATE_TICKS),
        .CT_INIT        (CT_INIT),
        .F_INIT         (F_INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Funct_Select(fsel),
        .Btn_Up      (btn_up),
        .Btn_Down    (btn_down),
        .Count_CT    (Count_CT),
        .Count_F     (Count_F),
        .Update      (Update)
    );

    always #5 clk = ~clk;

    // Behavioural model: time since press in ticks, lock flag, and plain integer counters.
    int         m_presc = 0;
    int         m_held = 0;
    int         m_s1[2], m_s2[2], m_deb[2], m_dcnt[2];
    int         m_raw[2];
    int         m_nheld, m_v;
    bit         m_active = 0, m_locked = 0, m_upd = 0, m_tick, m_do_step;
    logic [3:0] m_ct = CT_INIT;
    logic [3:0] m_f  = F_INIT;

    always @(posedge clk) begin
        if (rst) begin
            m_presc = 0; m_held = 0; m_active = 0; m_locked = 0; m_upd = 0;
            m_ct = CT_INIT; m_f = F_INIT;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_dcnt[b] = 0;
            end
        end else begin
            m_tick    = (m_presc == TICK_DIV - 1);
            m_nheld   = m_deb[0] + m_deb[1];
            m_do_step = 0;
            m_upd     = 0;
            if (m_locked) begin
                if (m_nheld == 0) m_locked = 0;
            end else if (m_nheld == 2) begin
                m_locked = 1; m_active = 0;
            end else if (m_nheld == 0) begin
                m_active = 0;
            end else if (!m_active) begin
                m_active = 1; m_held = 0; m_do_step = 1;
            end else if (m_tick) begin
                m_held++;
                if (m_held >= REP_DELAY_TICKS && (m_held - REP_DELAY_TICKS) % REP_RATE_TICKS == 0)
                    m_do_step = 1;
            end
            if (m_do_step) begin
                m_v = (fsel ? int'(m_ct) : int'(m_f)) + (m_deb[0] == 1 ? 1 : -1);
`ifdef PWM_SETTING_CTRL_WRAP_EN
                m_v = (m_v + 16) % 16;
`endif
                if (m_v >= 0 && m_v <= 15) begin
                    if (fsel) m_ct = m_v[3:0];
                    else      m_f  = m_v[3:0];
                    m_upd = 1;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] == m_deb[b]) m_dcnt[b] = 0;
                else if (m_tick) begin
                    m_dcnt[b]++;
                    if (m_dcnt[b] == DEB_TICKS) begin
                        m_deb[b] = 1 - m_deb[b]; m_dcnt[b] = 0;
                    end
                end
            end
            m_raw[0] = int'(btn_up);
            m_raw[1] = int'(btn_down);
            for (int b = 0; b < 2; b++) begin
                m_s2[b] = m_s1[b]; m_s1[b] = m_raw[b];
            end
            m_presc = m_tick ? 0 : m_presc + 1;
        end
    end

    task automatic test_reset();
        int pulses = 0;
        for (int c = 0; c < 205; c++) begin
            rst = (c < 5); btn_up = 0; btn_down = 0; fsel = 0;
            @(negedge clk);
            if (Update === 1'b1) pulses++;
            n_tests++;
            if ({Count_CT, Count_F, Update} !== {m_ct, m_f, m_upd}) begin
                n_fail++;
                $display("FAIL reset c=%0d got ct=%h f=%h upd=%b exp ct=%h f=%h upd=%b",
                         c, Count_CT, Count_F, Update, m_ct, m_f, m_upd);
            end
        end
        n_tests++;
        if (Count_CT !== 4'h8 || Count_F !== 4'h0 || pulses != 0) begin
            n_fail++;
            $display("FAIL reset_values got ct=%h f=%h pulses=%0d exp ct=8 f=0 pulses=0",
                     Count_CT, Count_F, pulses);
        end
    endtask

    task automatic test_single_step();
        int pulses = 0;
        for (int c = 0; c < 80; c++) begin
            fsel = 1; btn_up = (c < 20); btn_down = 0;
            @(negedge clk);
            if (Update === 1'b1) pulses++;
            n_tests++;
            if ({Count_CT, Count_F, Update} !== {m_ct, m_f, m_upd}) begin
                n_fail++;
                $display("FAIL single_step c=%0d got ct=%h f=%h upd=%b exp ct=%h f=%h upd=%b",
                         c, Count_CT, Count_F, Update, m_ct, m_f, m_upd);
            end
        end
        n_tests++;
        if (Count_CT !== 4'h9 || Count_F !== 4'h0 || pulses != 1) begin
            n_fail++;
            $display("FAIL single_step_end got ct=%h f=%h pulses=%0d exp ct=9 f=0 pulses=1",
                     Count_CT, Count_F, pulses);
        end
    endtask

    task automatic test_repeat();
        int step_at[$];
        bit wrapped = 0;
        logic [3:0] prev_f = Count_F;
        for (int c = 0; c < 240; c++) begin
            fsel = 0; btn_up = (c < 200); btn_down = 0;
            @(negedge clk);
            if (Update === 1'b1) step_at.push_back(c);
            if (prev_f == 4'hF && Count_F == 4'h0) wrapped = 1;
            prev_f = Count_F;
            n_tests++;
            if ({Count_CT, Count_F, Update} !== {m_ct, m_f, m_upd}) begin
                n_fail++;
                $display("FAIL repeat c=%0d got ct=%h f=%h upd=%b exp ct=%h f=%h upd=%b",
                         c, Count_CT, Count_F, Update, m_ct, m_f, m_upd);
            end
        end
        if (step_at.size() >= 2) begin
            n_tests++;
            if (step_at[1] - step_at[0] < 29 || step_at[1] - step_at[0] > 32) begin
                n_fail++;
                $display("FAIL repeat_delay got %0d cycles exp 29..32", step_at[1] - step_at[0]);
            end
        end
        for (int i = 2; i < step_at.size(); i++) begin
            n_tests++;
            if (step_at[i] - step_at[i-1] != 8) begin
                n_fail++;
                $display("FAIL repeat_rate step %0d got %0d cycles exp 8", i, step_at[i] - step_at[i-1]);
            end
        end
`ifdef PWM_SETTING_CTRL_WRAP_EN
        n_tests++;
        if (!wrapped) begin
            n_fail++;
            $display("FAIL repeat_wrap got no F->0 transition exp one");
        end
`else
        n_tests++;
        if (Count_F !== 4'hF || step_at.size() != 15 || wrapped) begin
            n_fail++;
            $display("FAIL repeat_saturate got f=%h steps=%0d wrapped=%0d exp f=F steps=15 wrapped=0",
                     Count_F, step_at.size(), wrapped);
        end
`endif
    endtask

    task automatic test_glitch();
        int pulses = 0;
        logic [3:0] ct0 = Count_CT, f0 = Count_F;
        for (int c = 0; c < 80; c++) begin
            fsel = 0; btn_up = 0; btn_down = (c < 40) ? ((c / 3) % 2 == 0) : 1'b0;
            @(negedge clk);
            if (Update === 1'b1) pulses++;
            n_tests++;
            if ({Count_CT, Count_F, Update} !== {m_ct, m_f, m_upd}) begin
                n_fail++;
                $display("FAIL glitch c=%0d got ct=%h f=%h upd=%b exp ct=%h f=%h upd=%b",
                         c, Count_CT, Count_F, Update, m_ct, m_f, m_upd);
            end
        end
        n_tests++;
        if (Count_CT !== ct0 || Count_F !== f0 || pulses != 0) begin
            n_fail++;
            $display("FAIL glitch_end got ct=%h f=%h pulses=%0d exp ct=%h f=%h pulses=0",
                     Count_CT, Count_F, pulses, ct0, f0);
        end
    endtask

    task automatic test_lock();
        int p_press = 0, p_lock = 0, p_again = 0;
        for (int c = 0; c < 320; c++) begin
            fsel = 1;
            btn_up   = (c < 200) || (c >= 240 && c < 260);
            btn_down = (c >= 20 && c < 60);
            @(negedge clk);
            if (Update === 1'b1) begin
                if (c < 60) p_press++;
                else if (c < 240) p_lock++;
                else p_again++;
            end
            n_tests++;
            if ({Count_CT, Count_F, Update} !== {m_ct, m_f, m_upd}) begin
                n_fail++;
                $display("FAIL lock c=%0d got ct=%h f=%h upd=%b exp ct=%h f=%h upd=%b",
                         c, Count_CT, Count_F, Update, m_ct, m_f, m_upd);
            end
        end
        n_tests++;
        if (p_press != 1 || p_lock != 0 || p_again != 1 || Count_CT !== 4'hB) begin
            n_fail++;
            $display("FAIL lock_phases got press=%0d lock=%0d again=%0d ct=%h exp 1 0 1 ct=B",
                     p_press, p_lock, p_again, Count_CT);
        end
    endtask

    task automatic test_reset_mid_hold();
        int pulses = 0;
        for (int c = 0; c < 140; c++) begin
            fsel = 1; btn_up = (c < 90); btn_down = 0; rst = (c == 60);
            @(negedge clk);
            if (c > 60 && Update === 1'b1) pulses++;
            n_tests++;
            if ({Count_CT, Count_F, Update} !== {m_ct, m_f, m_upd}) begin
                n_fail++;
                $display("FAIL reset_mid_hold c=%0d got ct=%h f=%h upd=%b exp ct=%h f=%h upd=%b",
                         c, Count_CT, Count_F, Update, m_ct, m_f, m_upd);
            end
            if (c == 60) begin
                n_tests++;
                if (Count_CT !== 4'h8 || Count_F !== 4'h0 || Update !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid_hold_now got ct=%h f=%h upd=%b exp ct=8 f=0 upd=0",
                             Count_CT, Count_F, Update);
                end
            end
        end
        rst = 0;
        n_tests++;
        if (pulses != 1 || Count_CT !== 4'h9 || Count_F !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid_hold_restep got pulses=%0d ct=%h f=%h exp pulses=1 ct=9 f=0",
                     pulses, Count_CT, Count_F);
        end
    endtask

    task automatic test_random();
        int seg = 0;
        int pat;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 80);
                pat = $urandom_range(0, 9);
                btn_up   = (pat <= 3) || (pat == 8);
                btn_down = (pat >= 4 && pat <= 7) || (pat == 8);
            end
            seg--;
            if ($urandom_range(0, 39) == 0) fsel = ~fsel;
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
            n_tests++;
            if ({Count_CT, Count_F, Update} !== {m_ct, m_f, m_upd}) begin
                n_fail++;
                $display("FAIL random c=%0d got ct=%h f=%h upd=%b exp ct=%h f=%h upd=%b",
                         c, Count_CT, Count_F, Update, m_ct, m_f, m_upd);
            end
        end
        rst = 0; btn_up = 0; btn_down = 0;
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_repeat();
        test_glitch();
        test_lock();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
